inst_prefetch_unit: RTL and testbench

INST_PREFETCH_UNIT -- requirements
Module: inst_prefetch_unit

---
 rtl/inst_prefetch_unit_pkg.sv | 14 +
 rtl/inst_prefetch_unit_fetch_queue.sv | 61 ++++++
 rtl/inst_prefetch_unit.sv | 154 +++++++++++++++
 tb/tb_inst_prefetch_unit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_prefetch_unit_pkg.sv
// Shared definitions for the instruction prefetch unit: fetch FSM encoding
// and the fixed AHB transfer size.
package inst_prefetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_ADDR = 2'd0,
    ST_DATA = 2'd1,
    ST_DROP = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/inst_prefetch_unit_fetch_queue.sv
// Circular prefetch queue holding {pc, instruction} entries; flush wins over
// push/pop and the head reads as zero whenever the queue is empty.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 96
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  always_ff @(posedge CLK) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    head = '0;
    if (count != '0) begin
      head = mem[rd_ptr];
    end
  end

endmodule

// File: rtl/inst_prefetch_unit.sv
// AHB-style instruction prefetcher: one outstanding read at a time, slices the
// bus beat into instructions and buffers them in fetch_queue; redirect flushes.
module inst_prefetch_unit
  import inst_prefetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            reset,
  output logic [XLEN-1:0] HADDR,
  output logic            HTRANS,
  output logic [2:0]      HSIZE,
  input  logic            HREADY,
  input  logic [XLEN-1:0] HRDATA,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            inst_ready,
  output logic            inst_valid,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  localparam int unsigned NSLOT = XLEN / ILEN;
  localparam int unsigned SELW  = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned QW    = XLEN + ILEN;

  fetch_state_e    state, state_n;
  logic [XLEN-1:0] fetch_pc, fetch_pc_n, haddr_q;
  logic            kill, kill_n;
  logic            push, pop;
  logic [CW-1:0]   count;
  logic [QW-1:0]   head;
  logic [SELW-1:0] slot;
  logic [ILEN-1:0] slice;
  logic [CW:0]     occ_pop, occ_push;
  logic            room_pop, room_push;

  generate
    if (NSLOT > 1) begin : g_slot
      assign slot = fetch_pc[SELW+1:2];
    end else begin : g_noslot
      assign slot = '0;
    end
  endgenerate

  always_comb begin
    slice = HRDATA[ILEN*slot +: ILEN];
  end

  assign pop = inst_valid & inst_ready & ~redirect_valid;

  // Occupancy after this edge, with and without the data-phase push.
  always_comb begin
    occ_pop   = {1'b0, count} - (CW+1)'(pop);
    occ_push  = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);
    room_pop  = occ_pop  < (CW+1)'(DEPTH);
    room_push = occ_push < (CW+1)'(DEPTH);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= ST_ADDR;
    end else begin
      state <= state_n;
    end
  end

  // A redirect during a stalled address phase sets kill so the phase finishes
  // on its original address and its data is then dropped.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    kill_n     = kill;
    push       = 1'b0;
    unique case (state)
      ST_ADDR: begin
        if (HREADY) begin
          state_n = (kill || redirect_valid) ? ST_DROP : ST_DATA;
          kill_n  = 1'b0;
        end else if (redirect_valid) begin
          kill_n = 1'b1;
        end
      end
      ST_DATA: begin
        if (redirect_valid) begin
          state_n = ST_DROP;
        end else if (HREADY) begin
          push       = 1'b1;
          fetch_pc_n = fetch_pc + XLEN'(4);
          state_n    = room_push ? ST_ADDR : ST_HOLD;
        end
      end
      ST_DROP: begin
        if (HREADY) begin
          state_n = (room_pop || redirect_valid) ? ST_ADDR : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect_valid || room_pop) begin
          state_n = ST_ADDR;
        end
      end
      default: state_n = ST_ADDR;
    endcase
    if (redirect_valid) begin
      fetch_pc_n = redirect_pc & ~XLEN'(3);
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      haddr_q  <= RESET_PC;
      kill     <= 1'b0;
    end else begin
      fetch_pc <= fetch_pc_n;
      kill     <= kill_n;
      if (state_n == ST_ADDR && state != ST_ADDR) begin
        haddr_q <= fetch_pc_n;
      end
    end
  end

  always_comb begin
    HTRANS = (state == ST_ADDR);
    HSIZE  = HSIZE_WORD;
    HADDR  = haddr_q;
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (QW)
  ) u_queue (
    .CLK       (CLK),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({fetch_pc, slice}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  always_comb begin
    inst_valid = (count != '0);
    inst       = head[ILEN-1:0];
    inst_pc    = head[QW-1:ILEN];
  end

endmodule

// File: tb/tb_inst_prefetch_unit.sv
// Self-checking bench: AHB slave model plus an in-order instruction-stream
// scoreboard (expected pc advances by 4, restarts at each redirect target).
module tb_inst_prefetch_unit;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] HADDR;
  logic        HTRANS;
  logic [2:0]  HSIZE;
  logic        HREADY = 1'b0;
  logic [63:0] HRDATA = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        inst_ready = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  int unsigned total = 0;
  int unsigned passed = 0;

  logic [63:0] exp_pc, data_addr, prev_haddr;
  bit          dpend, prev_stall;
  int unsigned cyc, issued, pops;
  logic [63:0] addr_log[$];
  int unsigned cyc_log[$];
  logic [63:0] pop_log[$];

  inst_prefetch_unit #(
    .XLEN     (XLEN),
    .ILEN     (ILEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .CLK            (CLK),
    .reset          (reset),
    .HADDR          (HADDR),
    .HTRANS         (HTRANS),
    .HSIZE          (HSIZE),
    .HREADY         (HREADY),
    .HRDATA         (HRDATA),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_ready     (inst_ready),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  function automatic logic [31:0] word(input logic [63:0] pc);
    return (pc[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [63:0] beat(input logic [63:0] a);
    logic [63:0] b;
    b = {a[63:3], 3'b000};
    return {word(b + 64'd4), word(b)};
  endfunction

  task automatic model_reset();
    exp_pc = RESET_PC;
    dpend = 1'b0;
    prev_stall = 1'b0;
    prev_haddr = '0;
    data_addr = '0;
    cyc = 0;
    issued = 0;
    pops = 0;
    addr_log.delete();
    cyc_log.delete();
    pop_log.delete();
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    reset = 1'b1;
    HREADY = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    reset = 1'b0;
  endtask

  // One bus cycle: drive inputs at the falling edge, act as slave, score pops.
  task automatic bus_cycle(input bit rdy, input bit hrdy, input bit redir, input logic [63:0] rpc);
    @(negedge CLK);
    cyc++;
    inst_ready = rdy;
    HREADY = hrdy;
    redirect_valid = redir;
    redirect_pc = rpc;
    HRDATA = dpend ? beat(data_addr) : {$urandom, $urandom};
    if (prev_stall) begin
      total++;
      if (HTRANS !== 1'b1 || HADDR !== prev_haddr)
        $display("FAIL addr_stable: HTRANS=%b HADDR=%h, expected HTRANS=1 HADDR=%h", HTRANS, HADDR, prev_haddr);
      else passed++;
    end
    if (dpend) begin
      total++;
      if (HTRANS !== 1'b0)
        $display("FAIL one_outstanding: HTRANS=%b during data phase, expected 0", HTRANS);
      else passed++;
    end
    if (inst_valid === 1'b1 && rdy && !redir) begin
      total++;
      if (inst_pc !== exp_pc || inst !== word(exp_pc))
        $display("FAIL pop_data: pc=%h inst=%h, expected pc=%h inst=%h", inst_pc, inst, exp_pc, word(exp_pc));
      else passed++;
      pop_log.push_back(inst_pc);
      pops++;
      exp_pc += 64'd4;
    end
    if (redir) exp_pc = rpc & ~64'd3;
    if (dpend && hrdy) dpend = 1'b0;
    if (HTRANS === 1'b1 && hrdy) begin
      dpend = 1'b1;
      data_addr = HADDR;
      addr_log.push_back(HADDR);
      cyc_log.push_back(cyc);
      issued++;
    end
    prev_stall = (HTRANS === 1'b1) && !hrdy;
    prev_haddr = HADDR;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(negedge CLK);
    total++;
    if (inst_valid !== 1'b0 || inst !== '0 || inst_pc !== '0)
      $display("FAIL reset_queue: valid=%b inst=%h pc=%h, expected 0 0 0", inst_valid, inst, inst_pc);
    else passed++;
    total++;
    if (HTRANS !== 1'b1 || HADDR !== RESET_PC || HSIZE !== 3'b010)
      $display("FAIL reset_bus: HTRANS=%b HADDR=%h HSIZE=%b, expected 1 %h 010", HTRANS, HADDR, HSIZE, RESET_PC);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    apply_reset();
    repeat (20) bus_cycle(1'b1, 1'b1, 1'b0, '0);
    total++;
    if (addr_log.size() < 5 || pop_log.size() < 3)
      $display("FAIL seq_progress: addrs=%0d pops=%0d, expected >=5 and >=3", addr_log.size(), pop_log.size());
    else begin
      passed++;
      for (int unsigned i = 0; i < 5; i++) begin
        total++;
        if (addr_log[i] !== RESET_PC + 64'(4 * i))
          $display("FAIL seq_haddr: got %h expected %h", addr_log[i], RESET_PC + 64'(4 * i));
        else passed++;
      end
      for (int unsigned i = 0; i < 4; i++) begin
        total++;
        if (cyc_log[i+1] - cyc_log[i] !== 2)
          $display("FAIL seq_spacing: got %0d cycles expected 2", cyc_log[i+1] - cyc_log[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_hold();
    int unsigned n;
    apply_reset();
    repeat (20) bus_cycle(1'b0, 1'b1, 1'b0, '0);
    total++;
    if (issued !== DEPTH || HTRANS !== 1'b0)
      $display("FAIL hold_fill: issued=%0d HTRANS=%b, expected %0d 0", issued, HTRANS, DEPTH);
    else passed++;
    n = issued;
    bus_cycle(1'b1, 1'b1, 1'b0, '0);
    bus_cycle(1'b0, 1'b1, 1'b0, '0);
    total++;
    if (issued !== n + 1 || HTRANS !== 1'b1)
      $display("FAIL hold_release: issued=%0d HTRANS=%b, expected %0d 1", issued, HTRANS, n + 1);
    else passed++;
  endtask

  task automatic test_stall_redirect();
    apply_reset();
    bus_cycle(1'b1, 1'b0, 1'b0, '0);
    bus_cycle(1'b1, 1'b0, 1'b1, 64'h100);
    bus_cycle(1'b1, 1'b0, 1'b0, '0);
    repeat (20) bus_cycle(1'b1, 1'b1, 1'b0, '0);
    total++;
    if (addr_log.size() < 2 || addr_log[0] !== RESET_PC || addr_log[1] !== 64'h100)
      $display("FAIL stall_redirect_addr: n=%0d first=%h second=%h, expected %h 100", addr_log.size(),
               addr_log.size() > 0 ? addr_log[0] : 64'hx, addr_log.size() > 1 ? addr_log[1] : 64'hx, RESET_PC);
    else passed++;
    total++;
    if (pop_log.size() < 1 || pop_log[0] !== 64'h100)
      $display("FAIL stall_redirect_pop: n=%0d first=%h, expected 100", pop_log.size(), pop_log.size() > 0 ? pop_log[0] : 64'hx);
    else passed++;
  endtask

  task automatic test_redirect_data();
    apply_reset();
    bus_cycle(1'b1, 1'b1, 1'b0, '0);
    bus_cycle(1'b1, 1'b1, 1'b1, 64'h203);
    bus_cycle(1'b1, 1'b1, 1'b0, '0);
    total++;
    if (inst_valid !== 1'b0)
      $display("FAIL redirect_data_flush: inst_valid=%b expected 0", inst_valid);
    else passed++;
    repeat (15) bus_cycle(1'b1, 1'b1, 1'b0, '0);
    total++;
    if (pop_log.size() < 1 || pop_log[0] !== 64'h200)
      $display("FAIL redirect_data_pc: n=%0d first=%h, expected 200", pop_log.size(), pop_log.size() > 0 ? pop_log[0] : 64'hx);
    else passed++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    repeat (3) bus_cycle(1'b0, 1'b1, 1'b0, '0);
    @(posedge CLK);
    #1;
    total++;
    if (inst_valid !== 1'b1 || HTRANS !== 1'b0)
      $display("FAIL async_pre: inst_valid=%b HTRANS=%b, expected 1 0", inst_valid, HTRANS);
    else passed++;
    reset = 1'b1;
    #1;
    total++;
    if (inst_valid !== 1'b0 || inst !== '0 || inst_pc !== '0 || HTRANS !== 1'b1 || HADDR !== RESET_PC)
      $display("FAIL async_reset: valid=%b inst=%h pc=%h HTRANS=%b HADDR=%h, expected 0 0 0 1 %h",
               inst_valid, inst, inst_pc, HTRANS, HADDR, RESET_PC);
    else passed++;
    model_reset();
    HREADY = 1'b0;
    inst_ready = 1'b0;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    repeat (10) bus_cycle(1'b1, 1'b1, 1'b0, '0);
    total++;
    if (addr_log.size() < 1 || addr_log[0] !== RESET_PC || pop_log.size() < 1 || pop_log[0] !== RESET_PC)
      $display("FAIL async_restart: addrs=%0d pops=%0d, expected first HADDR and inst_pc %h", addr_log.size(), pop_log.size(), RESET_PC);
    else passed++;
  endtask

  task automatic test_full_pop_redirect();
    apply_reset();
    repeat (12) bus_cycle(1'b0, 1'b1, 1'b0, '0);
    total++;
    if (inst_valid !== 1'b1 || HTRANS !== 1'b0)
      $display("FAIL full_pre: inst_valid=%b HTRANS=%b, expected 1 0", inst_valid, HTRANS);
    else passed++;
    bus_cycle(1'b1, 1'b1, 1'b1, 64'h40);
    bus_cycle(1'b1, 1'b1, 1'b0, '0);
    total++;
    if (inst_valid !== 1'b0)
      $display("FAIL full_redirect_flush: inst_valid=%b expected 0", inst_valid);
    else passed++;
    repeat (10) bus_cycle(1'b1, 1'b1, 1'b0, '0);
    total++;
    if (pop_log.size() < 1 || pop_log[0] !== 64'h40)
      $display("FAIL full_redirect_pc: n=%0d first=%h, expected 40", pop_log.size(), pop_log.size() > 0 ? pop_log[0] : 64'hx);
    else passed++;
  endtask

  task automatic test_random();
    bit          rdy, hr, rd;
    logic [63:0] rpc;
    apply_reset();
    for (int unsigned i = 0; i < 3000; i++) begin
      rdy = ($urandom_range(0, 9) < 7);
      hr  = ($urandom_range(0, 9) < 6);
      rd  = ($urandom_range(0, 99) < 3);
      rpc = {48'h0, 16'($urandom)};
      bus_cycle(rdy, hr, rd, rpc);
    end
    total++;
    if (pops < 100)
      $display("FAIL random_progress: pops=%0d expected >=100", pops);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hold();
    test_stall_redirect();
    test_redirect_data();
    test_async_reset();
    test_full_pop_redirect();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
